// File: rtl/pwm_duty_generator_pkg.sv
// Shared defaults, widths and duty-step arithmetic for the PWM duty generator.
// The display driver imports the same package so its percentage divisor tracks PWM_STEP.
package pwm_duty_generator_pkg;

  localparam int unsigned PWM_PERIOD   = 25000;
  localparam int unsigned PWM_STEP     = 250;
  localparam int unsigned PWM_DEBOUNCE = 1_000_000;
  localparam int unsigned PWM_REPEAT   = 12_500_000;
  localparam int unsigned PWM_W        = 15;
  localparam int unsigned SHADOW_W     = 16;

  typedef logic [SHADOW_W-1:0] shadow_t;

  // Packed {up, down} press pair; simultaneous presses cancel.
  typedef enum logic [1:0] {
    STEP_HOLD = 2'b00,
    STEP_DOWN = 2'b01,
    STEP_UP   = 2'b10,
    STEP_BOTH = 2'b11
  } step_cmd_e;

  // Saturating duty step; 16 bits so cur+step cannot wrap for any 15-bit period.
  function automatic shadow_t step_duty(input shadow_t cur, input step_cmd_e cmd,
                                        input shadow_t step, input shadow_t period);
    shadow_t sum;
    shadow_t result;
    sum    = cur + step;
    result = cur;
    case (cmd)
      STEP_UP:   result = (sum > period) ? period : sum;
      STEP_DOWN: result = (cur < step) ? '0 : (cur - step);
      default:   result = cur;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/pwm_duty_generator_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, debounce counter and 1-cycle press pulse.
// Optional auto-repeat while held, enabled by defining PWM_AUTO_REPEAT_EN.
module btn_debounce
  import pwm_duty_generator_pkg::*;
#(
  parameter int unsigned DEBOUNCE = PWM_DEBOUNCE,
  parameter int unsigned REPEAT   = PWM_REPEAT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned DW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);

  if (DEBOUNCE < 1 || REPEAT < 1) begin : g_bad_param
    $error("btn_debounce: DEBOUNCE and REPEAT must be at least 1");
  end

  logic          meta;
  logic          sync;
  logic          level;
  logic [DW-1:0] db_cnt;
  logic          flip;
  logic          rise;

  // Level flips on the DEBOUNCE-th consecutive sample that disagrees with it.
  assign flip = (sync != level) && (db_cnt == DB_LAST);
  assign rise = flip & sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      level  <= 1'b0;
      db_cnt <= '0;
    end else begin
      meta <= btn;
      sync <= meta;
      if (sync != level) begin
        if (flip) begin
          level  <= sync;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

`ifdef PWM_AUTO_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT + 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT - 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_fire;

  // Repeat timer runs only while the debounced level is high and is not releasing.
  assign rep_fire = level & ~flip & (rep_cnt == RP_LAST);

  always_ff @(posedge clk) begin
    if (rst || !level) begin
      rep_cnt <= '0;
    end else if (rep_cnt == RP_LAST) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) press <= 1'b0;
    else     press <= rise | rep_fire;
  end
`else
  always_ff @(posedge clk) begin
    if (rst) press <= 1'b0;
    else     press <= rise;
  end
`endif

endmodule

// File: rtl/pwm_duty_generator.sv
// PWM duty generator: button-driven shadow duty, period counter and registered comparator.
// Optional auto-repeat of held buttons is selected with PWM_AUTO_REPEAT_EN.
module pwm_duty_generator
  import pwm_duty_generator_pkg::*;
#(
  parameter int unsigned PERIOD   = PWM_PERIOD,
  parameter int unsigned STEP     = PWM_STEP,
  parameter int unsigned DEBOUNCE = PWM_DEBOUNCE,
  parameter int unsigned REPEAT   = PWM_REPEAT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN_UP,
  input  logic             BTN_DOWN,
  output logic             PWM_OUT,
  output logic [PWM_W-1:0] PWM
);

  localparam int unsigned   CW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam shadow_t       STEP_S   = SHADOW_W'(STEP);
  localparam shadow_t       PERIOD_S = SHADOW_W'(PERIOD);

  logic [CW-1:0] cnt;
  shadow_t       shadow;
  logic          up_press;
  logic          down_press;
  step_cmd_e     cmd;
  logic          wrap;

  btn_debounce #(.DEBOUNCE(DEBOUNCE), .REPEAT(REPEAT)) u_btn_up (
    .clk   (CLK),
    .rst   (RST),
    .btn   (BTN_UP),
    .press (up_press)
  );

  btn_debounce #(.DEBOUNCE(DEBOUNCE), .REPEAT(REPEAT)) u_btn_down (
    .clk   (CLK),
    .rst   (RST),
    .btn   (BTN_DOWN),
    .press (down_press)
  );

  assign cmd  = step_cmd_e'({up_press, down_press});
  assign wrap = (cnt == CNT_LAST);

  // Active duty is reloaded only at the period boundary so the waveform never glitches.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= '0;
      shadow  <= '0;
      PWM     <= '0;
      PWM_OUT <= 1'b0;
    end else begin
      cnt     <= wrap ? '0 : (cnt + CW'(1));
      shadow  <= step_duty(shadow, cmd, STEP_S, PERIOD_S);
      if (wrap) PWM <= PWM_W'(shadow);
      PWM_OUT <= SHADOW_W'(cnt) < SHADOW_W'(PWM);
    end
  end

endmodule

// File: tb/tb_pwm_duty_generator.sv
// Directed self-checking bench for pwm_duty_generator with a shortened period and debounce.
module tb_pwm_duty_generator;

  localparam int unsigned PERIOD   = 100;
  localparam int unsigned STEP     = 10;
  localparam int unsigned DEBOUNCE = 4;
  localparam int unsigned REPEAT   = 20;
`ifdef PWM_AUTO_REPEAT_EN
  localparam int EXP_HOLD = 40;
`else
  localparam int EXP_HOLD = 10;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        BTN_UP = 1'b0;
  logic        BTN_DOWN = 1'b0;
  logic        PWM_OUT;
  logic [14:0] PWM;

  int checks = 0;
  int errors = 0;
  int mcnt = 0;

  pwm_duty_generator #(
    .PERIOD(PERIOD), .STEP(STEP), .DEBOUNCE(DEBOUNCE), .REPEAT(REPEAT)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .BTN_UP   (BTN_UP),
    .BTN_DOWN (BTN_DOWN),
    .PWM_OUT  (PWM_OUT),
    .PWM      (PWM)
  );

  always #5 CLK = ~CLK;

  // Reference period position, derived from reset and elapsed cycles.
  always @(posedge CLK) begin
    if (RST) mcnt <= 0;
    else     mcnt <= (mcnt == int'(PERIOD) - 1) ? 0 : mcnt + 1;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_to_cnt(input int target);
    int n;
    n = 0;
    step();
    n++;
    while (mcnt != target && n < 250) begin
      step();
      n++;
    end
    if (mcnt != target) begin
      checks++;
      errors++;
      $display("FAIL wait_to_cnt: timed out at position %0d, wanted %0d", mcnt, target);
    end
  endtask

  task automatic measure_high(output int highs);
    highs = 0;
    repeat (PERIOD) begin
      step();
      if (PWM_OUT === 1'b1) highs++;
    end
  endtask

  task automatic press(input logic up, input logic down);
    BTN_UP = up;
    BTN_DOWN = down;
    repeat (8) step();
    BTN_UP = 1'b0;
    BTN_DOWN = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_reset();
    int highs;
    RST = 1'b1;
    step();
    step();
    checks++;
    if (PWM !== 15'd0) begin errors++; $display("FAIL reset_pwm: got %0d expected 0", PWM); end
    checks++;
    if (PWM_OUT !== 1'b0) begin errors++; $display("FAIL reset_pwm_out: got %b expected 0", PWM_OUT); end
    RST = 1'b0;
    highs = 0;
    repeat (3 * PERIOD) begin
      step();
      if (PWM_OUT !== 1'b0) highs++;
    end
    checks++;
    if (highs !== 0) begin errors++; $display("FAIL idle_pwm_out: got %0d non-low cycles expected 0", highs); end
    checks++;
    if (PWM !== 15'd0) begin errors++; $display("FAIL idle_pwm: got %0d expected 0", PWM); end
  endtask

  task automatic test_single_press();
    int pulses;
    int first;
    int highs;
    pulses = 0;
    first = -1;
    wait_to_cnt(10);
    BTN_UP = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (dut.up_press === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (i == 10) BTN_UP = 1'b0;
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL press_count: got %0d expected 1", pulses); end
    checks++;
    if (first !== 6) begin errors++; $display("FAIL press_latency: got %0d expected 6", first); end
    checks++;
    if (PWM !== 15'd0) begin errors++; $display("FAIL pwm_before_wrap: got %0d expected 0", PWM); end
    wait_to_cnt(0);
    checks++;
    if (PWM !== 15'd10) begin errors++; $display("FAIL pwm_after_wrap: got %0d expected 10", PWM); end
    measure_high(highs);
    checks++;
    if (highs !== 10) begin errors++; $display("FAIL duty_10: got %0d high cycles expected 10", highs); end
  endtask

  task automatic test_bounce();
    int pulses;
    pulses = 0;
    wait_to_cnt(5);
    for (int i = 0; i < 20; i++) begin
      BTN_UP = ((i / 2) % 2 == 0);
      step();
      if (dut.up_press === 1'b1) pulses++;
    end
    BTN_UP = 1'b0;
    repeat (12) begin
      step();
      if (dut.up_press === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL bounce_pulses: got %0d expected 0", pulses); end
    wait_to_cnt(0);
    checks++;
    if (PWM !== 15'd10) begin errors++; $display("FAIL bounce_pwm: got %0d expected 10", PWM); end
  endtask

  task automatic test_saturation();
    int highs;
    repeat (12) press(1'b1, 1'b0);
    wait_to_cnt(0);
    checks++;
    if (PWM !== 15'd100) begin errors++; $display("FAIL sat_high_pwm: got %0d expected 100", PWM); end
    measure_high(highs);
    checks++;
    if (highs !== 100) begin errors++; $display("FAIL sat_high_out: got %0d high cycles expected 100", highs); end
    repeat (11) press(1'b0, 1'b1);
    wait_to_cnt(0);
    checks++;
    if (PWM !== 15'd0) begin errors++; $display("FAIL sat_low_pwm: got %0d expected 0", PWM); end
    measure_high(highs);
    checks++;
    if (highs !== 0) begin errors++; $display("FAIL sat_low_out: got %0d high cycles expected 0", highs); end
  endtask

  task automatic test_both_and_wrap();
    int highs;
    repeat (5) press(1'b1, 1'b0);
    wait_to_cnt(0);
    checks++;
    if (PWM !== 15'd50) begin errors++; $display("FAIL setup_50: got %0d expected 50", PWM); end
    press(1'b1, 1'b1);
    wait_to_cnt(0);
    checks++;
    if (PWM !== 15'd50) begin errors++; $display("FAIL both_buttons: got %0d expected 50", PWM); end
    measure_high(highs);
    checks++;
    if (highs !== 50) begin errors++; $display("FAIL duty_50: got %0d high cycles expected 50", highs); end
    // Raw edge at position 93 puts the shadow update on the wrap edge itself.
    wait_to_cnt(93);
    BTN_UP = 1'b1;
    repeat (8) step();
    checks++;
    if (PWM !== 15'd50) begin errors++; $display("FAIL wrap_press_same: got %0d expected 50", PWM); end
    BTN_UP = 1'b0;
    wait_to_cnt(0);
    checks++;
    if (PWM !== 15'd60) begin errors++; $display("FAIL wrap_press_next: got %0d expected 60", PWM); end
  endtask

  task automatic test_hold_and_reset();
    int highs;
    RST = 1'b1;
    step();
    RST = 1'b0;
    BTN_UP = 1'b1;
    repeat (70) step();
    BTN_UP = 1'b0;
    repeat (12) step();
    wait_to_cnt(0);
    checks++;
    if (PWM !== 15'(EXP_HOLD)) begin errors++; $display("FAIL hold_pwm: got %0d expected %0d", PWM, EXP_HOLD); end
    measure_high(highs);
    checks++;
    if (highs !== EXP_HOLD) begin errors++; $display("FAIL hold_duty: got %0d expected %0d", highs, EXP_HOLD); end
    wait_to_cnt(37);
    RST = 1'b1;
    step();
    checks++;
    if (PWM !== 15'd0) begin errors++; $display("FAIL midreset_pwm: got %0d expected 0", PWM); end
    checks++;
    if (PWM_OUT !== 1'b0) begin errors++; $display("FAIL midreset_out: got %b expected 0", PWM_OUT); end
    RST = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_saturation();
    test_both_and_wrap();
    test_hold_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
